// File: rtl/helper_data_gen.sv
// BCH(264,192,t=8) systematic serial encoder producing PUF helper data RplusC = response ^ codeword.
// The default generator polynomial is derived at elaboration from the roots alpha^1..alpha^16 of GF(2^9).
package helper_data_gen_pkg;

    function automatic logic [8:0] gf_mul(input logic [8:0] a, input logic [8:0] b);
        logic [8:0] p;
        logic [8:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 9; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[7:0], 1'b0} ^ (x[8] ? 9'h011 : 9'h000);
        end
        return p;
    endfunction

    // g(x) = product of (x + alpha^j) over every j whose cyclotomic coset meets 1..16
    function automatic logic [72:0] bch_gen();
        logic [72:0][8:0] coef;
        logic [8:0]       a;
        logic [72:0]      g;
        int unsigned      e;
        logic             hit;
        coef    = '0;
        coef[0] = 9'd1;
        a       = 9'd1;
        for (int unsigned j = 1; j < 511; j++) begin
            a   = gf_mul(a, 9'd2);
            hit = 1'b0;
            e   = j;
            for (int unsigned k = 0; k < 9; k++) begin
                if (e <= 16) hit = 1'b1;
                e = (e * 2) % 511;
            end
            if (hit) begin
                for (int unsigned i = 72; i >= 1; i--)
                    coef[i] = coef[i-1] ^ gf_mul(coef[i], a);
                coef[0] = gf_mul(coef[0], a);
            end
        end
        for (int unsigned i = 0; i < 73; i++) g[i] = coef[i][0];
        return g;
    endfunction

endpackage

module helper_data_gen #(
    parameter int DATA_BITS = 192,
    parameter int N         = 264,
    parameter int PAR_BITS  = 72,
    parameter logic [PAR_BITS:0] GEN_POLY = helper_data_gen_pkg::bch_gen()
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] secret,
    input  logic [N-1:0]         response,
    output logic [N-1:0]         RplusC,
    output logic [N-1:0]         codeword,
    output logic                 busy,
    output logic                 ready
);

    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, ENCODE, FINISH} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] msg;
    logic [N-1:0]         resp_q;
    logic [PAR_BITS-1:0]  par;
    logic [CNT_W-1:0]     cnt;
    logic                 fb;

    always_comb begin
        fb = msg[DATA_BITS-1] ^ par[PAR_BITS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            msg      <= '0;
            resp_q   <= '0;
            par      <= '0;
            cnt      <= '0;
            codeword <= '0;
            RplusC   <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        msg    <= secret;
                        resp_q <= response;
                        par    <= '0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ENCODE;
                    end
                end
                ENCODE: begin
                    // msg rotates rather than shifts so it holds the original secret when FINISH builds the codeword
                    par <= {par[PAR_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY[PAR_BITS-1:0] : '0);
                    msg <= {msg[DATA_BITS-2:0], msg[DATA_BITS-1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_BITS - 1)) state <= FINISH;
                end
                FINISH: begin
                    codeword <= {msg, par};
                    RplusC   <= resp_q ^ {msg, par};
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_helper_data_gen.sv
// Randomized self-checking bench for helper_data_gen against a polynomial-division and syndrome reference.
module tb_helper_data_gen;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [191:0] secret;
    logic [263:0] response;
    logic [263:0] RplusC;
    logic [263:0] codeword;
    logic         busy;
    logic         ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0]  alog[511];
    int          lg[512];
    logic [72:0] g_ref;

    helper_data_gen #(.DATA_BITS(192), .N(264), .PAR_BITS(72)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .secret(secret), .response(response),
        .RplusC(RplusC), .codeword(codeword), .busy(busy), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] gmul(input logic [8:0] a, input logic [8:0] b);
        if (a == 9'd0 || b == 9'd0) return 9'd0;
        return alog[(lg[a] + lg[b]) % 511];
    endfunction

    // Generator as the GF(2) product of the minimal polynomials of alpha^1,3,...,15
    task automatic build_reference();
        logic [8:0]  a;
        logic [8:0]  mc[10];
        logic [72:0] prod;
        int          e;
        a = 9'd1;
        for (int i = 0; i < 511; i++) begin
            alog[i] = a;
            lg[a]   = i;
            a = {a[7:0], 1'b0} ^ (a[8] ? 9'h011 : 9'h000);
        end
        g_ref = 73'd1;
        for (int r = 1; r <= 15; r += 2) begin
            for (int i = 0; i < 10; i++) mc[i] = 9'd0;
            mc[0] = 9'd1;
            e = r;
            for (int k = 0; k < 9; k++) begin
                for (int i = 9; i >= 1; i--) mc[i] = mc[i-1] ^ gmul(mc[i], alog[e]);
                mc[0] = gmul(mc[0], alog[e]);
                e = (2 * e) % 511;
            end
            prod = '0;
            for (int i = 0; i < 10; i++) if (mc[i][0]) prod = prod ^ (g_ref << i);
            g_ref = prod;
        end
    endtask

    function automatic logic [263:0] exp_cw(input logic [191:0] s);
        logic [263:0] v;
        v = {s, 72'd0};
        for (int i = 263; i >= 72; i--) if (v[i]) v = v ^ (264'(g_ref) << (i - 72));
        return {s, v[71:0]};
    endfunction

    // Codeword must vanish at alpha^1..alpha^16
    function automatic logic synd_ok(input logic [263:0] cw);
        logic [8:0] s;
        for (int i = 1; i <= 16; i++) begin
            s = 9'd0;
            for (int b = 0; b < 264; b++) if (cw[b]) s = s ^ alog[(i * b) % 511];
            if (s != 9'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [191:0] rnd192();
        logic [191:0] r = '0;
        for (int i = 0; i < 6; i++) r = (r << 32) | 192'($urandom);
        return r;
    endfunction

    function automatic logic [263:0] rnd264();
        logic [263:0] r = '0;
        for (int i = 0; i < 9; i++) r = (r << 32) | 264'($urandom);
        return r;
    endfunction

    task automatic run_job(input logic [191:0] s, input logic [263:0] r, input int pulse_at,
                           output logic [263:0] cw, output logic [263:0] rp, output int lat);
        @(negedge clk);
        secret   = s;
        response = r;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", 264'(busy), 264'd1);
        check("accept_ready", 264'(ready), 264'd0);
        secret   = rnd192();
        response = rnd264();
        lat = 0;
        while (ready !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            start = (pulse_at != 0 && lat == pulse_at);
        end
        start = 1'b0;
        check("latency", 264'(lat), 264'd193);
        check("done_busy", 264'(busy), 264'd0);
        cw = codeword;
        rp = RplusC;
    endtask

    task automatic check_result(input logic [191:0] s, input logic [263:0] r,
                                input logic [263:0] cw, input logic [263:0] rp);
        check("codeword", cw, exp_cw(s));
        check("rplusc", rp, r ^ exp_cw(s));
        check("syndrome", 264'(synd_ok(cw)), 264'd1);
    endtask

    initial begin
        logic [191:0] sa, sb, s;
        logic [263:0] ra, rb, rab, r, cwa, cwb, cwab, cw, rp, a5;
        int           lat;

        rst_n = 1'b0; start = 1'b0; secret = '0; response = '0;
        build_reference();
        #12;
        check("rst_rplusc", RplusC, 264'd0);
        check("rst_codeword", codeword, 264'd0);
        check("rst_busy", 264'(busy), 264'd0);
        check("rst_ready", 264'(ready), 264'd0);
        @(negedge clk) rst_n = 1'b1;

        a5 = {8'h00, {32{8'hA5}}};
        run_job('0, a5, 0, cw, rp, lat);
        check("zero_codeword", cw, 264'd0);
        check("zero_rplusc", rp, a5);
        check("zero_ready", 264'(ready), 264'd1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_ready", 264'(ready), 264'd1);
        check("hold_rplusc", RplusC, a5);

        run_job(192'd1, '0, 0, cw, rp, lat);
        check("one_codeword", cw, {191'd0, 1'b1, g_ref[71:0]});
        check("one_rplusc", rp, cw);
        check("one_syndrome", 264'(synd_ok(cw)), 264'd1);

        sa = rnd192(); sb = rnd192(); ra = rnd264(); rb = rnd264(); rab = rnd264();
        run_job(sa, ra, 0, cwa, rp, lat);
        check_result(sa, ra, cwa, rp);
        run_job(sb, rb, 0, cwb, rp, lat);
        check_result(sb, rb, cwb, rp);
        run_job(sa ^ sb, rab, 0, cwab, rp, lat);
        check_result(sa ^ sb, rab, cwab, rp);
        check("linearity", cwab, cwa ^ cwb);

        s = rnd192(); r = rnd264();
        run_job(s, r, 50, cw, rp, lat);
        check_result(s, r, cw, rp);
        @(posedge clk); #1;
        check("pulse_no_restart", 264'(busy), 264'd0);
        check("pulse_still_ready", 264'(ready), 264'd1);

        @(negedge clk);
        secret = rnd192(); response = rnd264(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 264'(busy), 264'd0);
        check("midrst_ready", 264'(ready), 264'd0);
        check("midrst_codeword", codeword, 264'd0);
        check("midrst_rplusc", RplusC, 264'd0);
        @(negedge clk) rst_n = 1'b1;
        s = rnd192(); r = rnd264();
        run_job(s, r, 0, cw, rp, lat);
        check_result(s, r, cw, rp);

        for (int i = 0; i < 4; i++) begin
            s = rnd192(); r = rnd264();
            run_job(s, r, 0, cw, rp, lat);
            check_result(s, r, cw, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
